muldiv_unit: RTL

//  Iterative RV32M multiply/divide unit. Sits directly downstream of the register file (rf):

---
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per clock.
// Optional build macro MULDIV_EARLY_OUT_EN: trivial cases (div by zero, signed overflow, mul by zero) finish early.
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [XLEN-1:0]      a,
  input  logic [XLEN-1:0]      b,
  input  logic [REGADDR_W-1:0] rd_in,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic [XLEN-1:0]      result,
  output logic [REGADDR_W-1:0] rd_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                 state, state_next;
  logic [2:0]             op_lat;
  logic                   sa, sb, div0, ovf, fin;
  logic [XLEN-1:0]        a_raw, hi, lo, mcand;
  logic [4:0]             count;
  logic [REGADDR_W-1:0]   rd_lat;

  logic                   accept, skip, sa_in, sb_in, div0_in, ovf_in;
  logic [XLEN-1:0]        mag_a, mag_b, step_hi, step_lo;
  logic [XLEN:0]          mul_sum, rem_shift;

  // Sign/magnitude fix-up and special-case overrides applied after the unsigned iteration.
  function automatic logic [XLEN-1:0] finish_result(
    input logic [2:0]      f_op,
    input logic            f_sa,
    input logic            f_sb,
    input logic            f_div0,
    input logic            f_ovf,
    input logic [XLEN-1:0] f_a,
    input logic [XLEN-1:0] f_hi,
    input logic [XLEN-1:0] f_lo
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res;
    prod = (f_sa ^ f_sb) ? -{f_hi, f_lo} : {f_hi, f_lo};
    quo  = (f_sa ^ f_sb) ? -f_lo : f_lo;
    rem  = f_sa ? -f_hi : f_hi;
    case (f_op)
      3'b000:                 res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (f_div0)     res = {XLEN{1'b1}};
        else if (f_ovf) res = {1'b1, {(XLEN-1){1'b0}}};
        else            res = quo;
      end
      3'b110, 3'b111: begin
        if (f_div0)     res = f_a;
        else if (f_ovf) res = {XLEN{1'b0}};
        else            res = rem;
      end
      default:                res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  assign accept  = start && !flush && ((state == IDLE) || (state == DONE));
  assign sa_in   = a[XLEN-1] && ((op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110));
  assign sb_in   = b[XLEN-1] && ((op == 3'b001) || (op == 3'b100) || (op == 3'b110));
  assign mag_a   = sa_in ? -a : a;
  assign mag_b   = sb_in ? -b : b;
  assign div0_in = (b == {XLEN{1'b0}});
  assign ovf_in  = ((op == 3'b100) || (op == 3'b110)) &&
                   (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});

`ifdef MULDIV_EARLY_OUT_EN
  assign skip = op[2] ? (div0_in || ovf_in) : ((a == {XLEN{1'b0}}) || div0_in);
`else
  assign skip = 1'b0;
`endif

  // One radix-2 step: multiply shifts right with add, divide shifts left with trial subtract.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
    rem_shift = {hi, lo[XLEN-1]};
    step_hi   = hi;
    step_lo   = lo;
    if (op_lat[2]) begin
      if (rem_shift >= {1'b0, mcand}) begin
        step_hi = rem_shift[XLEN-1:0] - mcand;
        step_lo = {lo[XLEN-2:0], 1'b1};
      end else begin
        step_hi = rem_shift[XLEN-1:0];
        step_lo = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // State register with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == CALC);
      done  <= (state_next == DONE);
    end
  end

  // Next-state logic; a committed DONE is never cancelled.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = CALC;
        else        state_next = IDLE;
      end
      CALC: begin
        if (flush)    state_next = IDLE;
        else if (fin) state_next = DONE;
        else          state_next = CALC;
      end
      DONE: begin
        if (accept) state_next = CALC;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration and final result write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_lat <= 3'b000;
      sa     <= 1'b0;
      sb     <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      fin    <= 1'b0;
      a_raw  <= {XLEN{1'b0}};
      hi     <= {XLEN{1'b0}};
      lo     <= {XLEN{1'b0}};
      mcand  <= {XLEN{1'b0}};
      count  <= 5'd0;
      rd_lat <= {REGADDR_W{1'b0}};
      result <= {XLEN{1'b0}};
      rd_out <= {REGADDR_W{1'b0}};
    end else if (accept) begin
      op_lat <= op;
      sa     <= sa_in;
      sb     <= sb_in;
      div0   <= div0_in;
      ovf    <= ovf_in;
      fin    <= skip;
      a_raw  <= a;
      hi     <= {XLEN{1'b0}};
      lo     <= skip ? {XLEN{1'b0}} : (op[2] ? mag_a : mag_b);
      mcand  <= op[2] ? mag_b : mag_a;
      count  <= 5'd31;
      rd_lat <= rd_in;
    end else if ((state == CALC) && !flush) begin
      if (!fin) begin
        hi <= step_hi;
        lo <= step_lo;
        if (count == 5'd0) fin <= 1'b1;
        else               count <= count - 5'd1;
      end else begin
        result <= finish_result(op_lat, sa, sb, div0, ovf, a_raw, hi, lo);
        rd_out <= rd_lat;
      end
    end else begin
      fin <= fin;
    end
  end

endmodule
